// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, LSB-first data, optional parity, stop bit(s)
// The line is driven straight from serial_q, which is computed from the next state.
module uart_tx #(
  parameter int SYSCLK    = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sysclk_in,
  input  logic                 nrst_in,
  input  logic                 tx_valid_in,
  input  logic [DATA_BITS-1:0] tx_data_in,
  output logic                 tx_ready_out,
  output logic                 tx_busy_out,
  output logic                 tx_done_out,
  output logic                 tx_serial_out
);

  localparam int CLKS_PER_BIT = SYSCLK / BAUD_RATE;
  localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_tx: illegal parameters (CLKS_PER_BIT must be >= 2)");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   serial_q, serial_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    bit_end = (baud_q == BAUD_LAST);

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid_in) begin
          shift_d = tx_data_in;
          par_d   = (PARITY == 1) ? ~^tx_data_in : ^tx_data_in;
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level for the coming cycle follows the state being entered.
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = par_q;
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  assign tx_ready_out  = (state_q == S_IDLE);
  assign tx_busy_out   = (state_q != S_IDLE);
  assign tx_done_out   = done_q;
  assign tx_serial_out = serial_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx across parity, stop-bit and baud configurations
module tb_uart_tx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] vld   = '0;
  logic [7:0] dat [5];
  wire  [4:0] rdy, bsy, dn, ser;
  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: 8N1 @10 clk/bit, 1: even parity, 2: odd parity, 3: two stop bits, 4: defaults (868 clk/bit)
  uart_tx #(.SYSCLK(1_000_000), .BAUD_RATE(100_000)) u_n1 (
    .sysclk_in(clk), .nrst_in(rst_n), .tx_valid_in(vld[0]), .tx_data_in(dat[0]),
    .tx_ready_out(rdy[0]), .tx_busy_out(bsy[0]), .tx_done_out(dn[0]), .tx_serial_out(ser[0]));
  uart_tx #(.SYSCLK(1_000_000), .BAUD_RATE(100_000), .PARITY(2)) u_even (
    .sysclk_in(clk), .nrst_in(rst_n), .tx_valid_in(vld[1]), .tx_data_in(dat[1]),
    .tx_ready_out(rdy[1]), .tx_busy_out(bsy[1]), .tx_done_out(dn[1]), .tx_serial_out(ser[1]));
  uart_tx #(.SYSCLK(1_000_000), .BAUD_RATE(100_000), .PARITY(1)) u_odd (
    .sysclk_in(clk), .nrst_in(rst_n), .tx_valid_in(vld[2]), .tx_data_in(dat[2]),
    .tx_ready_out(rdy[2]), .tx_busy_out(bsy[2]), .tx_done_out(dn[2]), .tx_serial_out(ser[2]));
  uart_tx #(.SYSCLK(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2)) u_s2 (
    .sysclk_in(clk), .nrst_in(rst_n), .tx_valid_in(vld[3]), .tx_data_in(dat[3]),
    .tx_ready_out(rdy[3]), .tx_busy_out(bsy[3]), .tx_done_out(dn[3]), .tx_serial_out(ser[3]));
  uart_tx u_def (
    .sysclk_in(clk), .nrst_in(rst_n), .tx_valid_in(vld[4]), .tx_data_in(dat[4]),
    .tx_ready_out(rdy[4]), .tx_busy_out(bsy[4]), .tx_done_out(dn[4]), .tx_serial_out(ser[4]));

  function automatic int cpb_of(input int k);
    return (k == 4) ? 868 : 10;
  endfunction
  function automatic int par_of(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction
  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference frame: list of line levels, one entry per bit time.
  task automatic model_frame(input int k, input logic [7:0] d, output int nb, output logic [15:0] bits);
    bit q[$];
    int ones;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (par_of(k) != 0) begin
      ones = $countones(d);
      q.push_back((par_of(k) == 2) ? (ones % 2 == 1) : (ones % 2 == 0));
    end
    for (int s = 0; s < stop_of(k); s++) q.push_back(1'b1);
    nb   = q.size();
    bits = '0;
    foreach (q[i]) bits[i] = q[i];
  endtask

  task automatic send_check(input int k, input logic [7:0] d, input int nb, input logic [15:0] bits,
                            input int poke, input string name);
    int cpb;
    int err_line [16];
    int err_ctl, err_done, idle_err;
    cpb = cpb_of(k);
    err_ctl = 0; err_done = 0; idle_err = 0;
    foreach (err_line[i]) err_line[i] = 0;
    @(negedge clk);
    check({name, "_ready_before"}, rdy[k], 1);
    vld[k] = 1'b1;
    dat[k] = d;
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
    dat[k] = 8'($urandom);
    for (int c = 0; c < nb * cpb; c++) begin
      @(negedge clk);
      if (ser[k] !== bits[c / cpb]) err_line[c / cpb]++;
      if (rdy[k] !== 1'b0 || bsy[k] !== 1'b1) err_ctl++;
      if (dn[k] !== 1'b0) err_done++;
      if (poke >= 0 && c == poke) begin
        vld[k] = 1'b1;
        dat[k] = ~d;
      end else if (poke >= 0 && c == poke + 1) begin
        vld[k] = 1'b0;
      end
    end
    for (int b = 0; b < nb; b++) check($sformatf("%s_bit%0d_bad_cycles", name, b), err_line[b], 0);
    check({name, "_ready_busy_bad_cycles"}, err_ctl, 0);
    check({name, "_done_early_cycles"}, err_done, 0);
    @(negedge clk);
    check({name, "_done_pulse"}, dn[k], 1);
    check({name, "_ready_after"}, rdy[k], 1);
    check({name, "_busy_after"}, bsy[k], 0);
    check({name, "_line_idle"}, ser[k], 1);
    @(negedge clk);
    check({name, "_done_single"}, dn[k], 0);
    if (poke >= 0) begin
      repeat (3 * cpb) begin
        @(negedge clk);
        if (ser[k] !== 1'b1 || bsy[k] !== 1'b0) idle_err++;
      end
      check({name, "_no_extra_frame"}, idle_err, 0);
    end
  endtask

  // Behavioural receiver: mid-bit sampling, parity and stop verification.
  task automatic rx_frame(input int k, output logic [7:0] d, output int t0, output bit ok);
    int cpb, n, ones;
    logic pbit;
    cpb = cpb_of(k);
    ok = 1'b1; d = '0; n = 0; t0 = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ser[k] !== 1'b0 && n < 40 * cpb);
    if (ser[k] !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    t0 = cyc;
    repeat (cpb / 2) @(negedge clk);
    if (ser[k] !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk);
      d[i] = ser[k];
    end
    if (par_of(k) != 0) begin
      repeat (cpb) @(negedge clk);
      ones = $countones(d);
      pbit = (par_of(k) == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      if (ser[k] !== pbit) ok = 1'b0;
    end
    for (int s = 0; s < stop_of(k); s++) begin
      repeat (cpb) @(negedge clk);
      if (ser[k] !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic stream(input int k, input logic [7:0] w [16], input int n, input string name);
    int period;
    logic [7:0] d;
    int t0, tprev;
    bit ok;
    period = (1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k)) * cpb_of(k) + 1;
    tprev = 0;
    fork
      begin : drv
        int i, g;
        i = 0; g = 0;
        while (i < n && g < n * period + 100) begin
          @(negedge clk);
          g++;
          if (rdy[k]) begin
            vld[k] = 1'b1;
            dat[k] = w[i];
            i++;
          end else begin
            dat[k] = 8'($urandom);
          end
        end
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
      end
      begin : rcv
        for (int j = 0; j < n; j++) begin
          rx_frame(k, d, t0, ok);
          check($sformatf("%s_frame%0d_ok", name, j), ok, 1);
          check($sformatf("%s_frame%0d_data", name, j), d, w[j]);
          if (j > 0) check($sformatf("%s_frame%0d_spacing", name, j), t0 - tprev, period);
          tprev = t0;
        end
      end
    join
  endtask

  typedef struct {
    int          k;
    logic [7:0]  d;
    int          nb;
    logic [15:0] bits;
    int          poke;
    string       name;
  } vec_t;

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl [4];
    logic [7:0] lb [16];
    logic [7:0] d;
    int         nb, idle_err;
    logic [15:0] bits;

    tbl[0] = '{0, 8'hA5, 10, 16'h034A, -1, "a5_8n1"};
    tbl[1] = '{1, 8'h07, 11, 16'h060E, -1, "07_even"};
    tbl[2] = '{2, 8'h07, 11, 16'h040E, -1, "07_odd"};
    tbl[3] = '{3, 8'h3C, 11, 16'h0678, 30, "3c_2stop"};
    foreach (dat[i]) dat[i] = '0;
    foreach (lb[i]) lb[i] = '0;

    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rst_line_%0d", k), ser[k], 1);
      check($sformatf("rst_ready_%0d", k), rdy[k], 1);
      check($sformatf("rst_busy_%0d", k), bsy[k], 0);
      check($sformatf("rst_done_%0d", k), dn[k], 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      send_check(tbl[i].k, tbl[i].d, tbl[i].nb, tbl[i].bits, tbl[i].poke, tbl[i].name);

    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55;
    stream(0, lb, 3, "b2b");

    // Reset in the middle of a frame.
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 8'hA5;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (45) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_line", ser[0], 1);
    check("midrst_ready", rdy[0], 1);
    check("midrst_busy", bsy[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_err = 0;
    repeat (20) begin
      @(negedge clk);
      if (ser[0] !== 1'b1 || bsy[0] !== 1'b0) idle_err++;
    end
    check("midrst_word_lost", idle_err, 0);
    send_check(0, 8'h81, 10, 16'h0302, -1, "81_after_rst");

    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 6; r++) begin
        d = 8'($urandom);
        model_frame(k, d, nb, bits);
        send_check(k, d, nb, bits, -1, $sformatf("rnd_k%0d_%0d", k, r));
      end
    end
    for (int i = 0; i < 4; i++) lb[i] = 8'($urandom);
    stream(1, lb, 4, "rnd_stream_even");

    lb[0] = 8'h23; lb[1] = 8'h25; lb[2] = 8'hFF; lb[3] = 8'h13;
    lb[4] = 8'h00; lb[5] = 8'h11; lb[6] = 8'h99; lb[7] = 8'h11;
    stream(4, lb, 8, "loop_default");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
